// File: rtl/alu_result_queue.sv
// ============================================================================
// alu_result_queue : captures ALU unit results one cycle after issue, tags them
// with opcode/flags and buffers them in a FWFT FIFO with issue-side credit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [3:0]               iss_opcode,
    input  logic [9:0]               unit_res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [9:0]               res_data,
    output logic [3:0]               res_opcode,
    output logic                     res_zero,
    output logic                     res_ovf,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [9:0] data;
        logic [3:0] opcode;
        logic       zero;
        logic       ovf;
        logic       err;
    } entry_t;

    logic          p_valid;
    logic [3:0]    p_opcode;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        mem [DEPTH];
    entry_t        push_entry;
    entry_t        head;
    logic          accept;
    logic          push;
    logic          pop;
    logic          illegal;
    logic [CW:0]   credit_used;

    // Pending issue is counted as occupied so an accepted issue always has a slot.
    assign credit_used = (CW+1)'(count) + (CW+1)'(p_valid);
    assign iss_ready   = credit_used < (CW+1)'(DEPTH);
    assign res_valid   = (count != '0);
    assign accept      = iss_valid && iss_ready;
    assign push        = p_valid;
    assign pop         = res_valid && res_ready;

    // Units hold stale output for illegal opcodes, so their result is discarded.
    assign illegal = (p_opcode[3:2] == 2'b11);

    always_comb begin
        push_entry        = '0;
        push_entry.data   = illegal ? 10'd0 : unit_res;
        push_entry.opcode = p_opcode;
        push_entry.err    = illegal;
        push_entry.zero   = (push_entry.data == 10'd0);
        push_entry.ovf    = (push_entry.data[9:4] != 6'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid  <= 1'b0;
            p_opcode <= 4'd0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_opcode <= iss_opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head       = mem[rd_ptr];
    assign res_data   = res_valid ? head.data   : 10'd0;
    assign res_opcode = res_valid ? head.opcode : 4'd0;
    assign res_zero   = res_valid ? head.zero   : 1'b0;
    assign res_ovf    = res_valid ? head.ovf    : 1'b0;
    assign res_err    = res_valid ? head.err    : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_queue.sv
// ============================================================================
// tb_alu_result_queue : scoreboard plus vector-table bench for alu_result_queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iss_valid = 1'b0;
    logic       iss_ready;
    logic [3:0] iss_opcode = 4'd0;
    logic [9:0] unit_res = 10'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [9:0] res_data;
    logic [3:0] res_opcode;
    logic       res_zero;
    logic       res_ovf;
    logic       res_err;
    logic [2:0] count;

    alu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
        .unit_res(unit_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .res_zero(res_zero), .res_ovf(res_ovf),
        .res_err(res_err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [9:0] d;
        bit [3:0] op;
        bit       z;
        bit       o;
        bit       e;
    } exp_t;

    typedef struct {
        bit       iv;
        bit [3:0] op;
        bit       rr;
        bit [9:0] ur;
        int       exp_cnt;
        bit       exp_rdy;
    } vec_t;

    exp_t     exp_q[$];
    bit       pend = 1'b0;
    bit [3:0] pend_op = 4'd0;
    int       checks = 0;
    int       errors = 0;
    int       issued = 0;
    int       popped = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit [3:0] op, input bit [9:0] ur);
        exp_t e;
        e.op = op;
        e.e  = (op >= 4'd12);
        e.d  = e.e ? 10'd0 : ur;
        e.z  = (e.d == 10'd0);
        e.o  = (e.d >= 10'd16);
        return e;
    endfunction

    // Entered #1 after a rising edge; leaves #1 after the next rising edge.
    task automatic tick(input bit iv, input bit [3:0] op, input bit rr, input bit [9:0] ur);
        bit exp_valid;
        bit exp_rdy;
        iss_valid  = iv;
        iss_opcode = op;
        res_ready  = rr;
        unit_res   = ur;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_rdy   = ((exp_q.size() + int'(pend)) < DEPTH);
        check("res_valid", int'(res_valid), int'(exp_valid));
        check("iss_ready", int'(iss_ready), int'(exp_rdy));
        check("count", int'(count), exp_q.size());
        if (exp_valid) begin
            check("head_data", int'(res_data), int'(exp_q[0].d));
            check("head_tag", int'({res_opcode, res_zero, res_ovf, res_err}),
                  int'({exp_q[0].op, exp_q[0].z, exp_q[0].o, exp_q[0].e}));
            if (rr) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end else begin
            check("idle_out", int'({res_data, res_opcode, res_zero, res_ovf, res_err}), 0);
        end
        if (pend) exp_q.push_back(mk(pend_op, ur));
        pend    = iv && exp_rdy;
        pend_op = op;
        if (pend) issued++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b1, 10'd0);
    endtask

    vec_t     tbl[10];
    bit [3:0] stream_ops[8];
    int       i0;
    int       p0;

    initial begin
        // Backpressure table: 4 accepted, 5th refused, then drained in order.
        tbl[0] = '{1, 4'd0, 0, 10'h000, 0, 1};
        tbl[1] = '{1, 4'd1, 0, 10'h011, 1, 1};
        tbl[2] = '{1, 4'd2, 0, 10'h022, 2, 1};
        tbl[3] = '{1, 4'd3, 0, 10'h000, 3, 0};
        tbl[4] = '{1, 4'd4, 0, 10'h033, 4, 0};
        tbl[5] = '{1, 4'd5, 0, 10'h044, 4, 0};
        tbl[6] = '{0, 4'd0, 1, 10'h000, 3, 1};
        tbl[7] = '{0, 4'd0, 1, 10'h000, 2, 1};
        tbl[8] = '{0, 4'd0, 1, 10'h000, 1, 1};
        tbl[9] = '{0, 4'd0, 1, 10'h000, 0, 1};
        stream_ops = '{4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0101};

        #2;
        check("rst_valid", int'(res_valid), 0);
        check("rst_ready", int'(iss_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_out", int'({res_data, res_opcode, res_zero, res_ovf, res_err}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single issue: visible two edges after issue.
        tick(1'b1, 4'b0110, 1'b0, 10'h000);
        check("lat_not_yet", int'(res_valid), 0);
        tick(1'b0, 4'd0, 1'b0, 10'h001);
        check("single_valid", int'(res_valid), 1);
        check("single_data", int'(res_data), 10'h001);
        check("single_op", int'(res_opcode), 4'b0110);
        check("single_flags", int'({res_zero, res_ovf, res_err}), 0);
        drain(2);

        // Streaming with res_ready high.
        for (int i = 0; i <= 8; i++) begin
            tick(i < 8, (i < 8) ? stream_ops[i] : 4'd0, 1'b1,
                 (i == 0) ? 10'h000 :
                 (stream_ops[i-1] == 4'b1001) ? 10'h3F0 : 10'(stream_ops[i-1]) + 10'd1);
            check("stream_cnt_le2", int'(count <= 3'd2), 1);
        end
        drain(3);

        // Backpressure from the vector table.
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].iv, tbl[i].op, tbl[i].rr, tbl[i].ur);
            check("tbl_count", int'(count), tbl[i].exp_cnt);
            check("tbl_ready", int'(iss_ready), int'(tbl[i].exp_rdy));
        end

        // Illegal opcode ignores unit_res.
        tick(1'b1, 4'b1110, 1'b0, 10'h000);
        tick(1'b0, 4'd0, 1'b0, 10'h2AA);
        check("illegal_data", int'(res_data), 0);
        check("illegal_flags", int'({res_opcode, res_zero, res_ovf, res_err}), int'({4'b1110, 1'b1, 1'b0, 1'b1}));
        drain(2);

        // Simultaneous push and pop at count=1.
        tick(1'b1, 4'd3, 1'b0, 10'h000);
        tick(1'b1, 4'd7, 1'b0, 10'h005);
        tick(1'b0, 4'd0, 1'b1, 10'h009);
        check("pp_count", int'(count), 1);
        check("pp_head_op", int'(res_opcode), 4'd7);
        check("pp_head_data", int'(res_data), 10'h009);
        drain(2);

        // Random traffic for pointer wrap.
        i0 = issued;
        p0 = popped;
        for (int i = 0; i < 40; i++) begin
            tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, 10'($urandom_range(0, 1023)));
        end
        drain(8);
        check("wrap_xfers_ge12", int'((popped - p0) >= 3 * DEPTH), 1);
        check("wrap_no_loss", popped - p0, issued - i0);

        // Reset with count=3 and p_valid=1.
        for (int i = 0; i < 4; i++) tick(1'b1, 4'(i + 1), 1'b0, 10'(i * 3 + 1));
        check("pre_rst_count", int'(count), 3);
        iss_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_ready", int'(iss_ready), 1);
        check("mid_rst_out", int'({res_data, res_opcode, res_zero, res_ovf, res_err}), 0);
        exp_q.delete();
        pend = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, 4'd0, 1'b1, 10'h000);
        tick(1'b0, 4'd0, 1'b1, 10'h000);
        p0 = popped;
        tick(1'b1, 4'd2, 1'b1, 10'h000);
        tick(1'b0, 4'd0, 1'b1, 10'h055);
        drain(3);
        check("post_rst_one_result", popped - p0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
